car_alarm_siren_ctrl: RTL and testbench

- Receiving end of the CarAlarmSignal line produced by the car-alarm gate logic.
- Debounces the alarm request, then drives the siren with a beep pattern and holds the hazard lights on.
- Sounding ends on driver silence or after a maximum duration, followed by a re-trigger holdoff.
- Sits between the alarm detection logic and the siren/lamp drivers. All outputs are registered.

---
 rtl/car_alarm_pkg.sv | 30 +++
 rtl/car_alarm_beep_gen.sv | 47 ++++
 rtl/car_alarm_siren_ctrl.sv | 140 ++++++++++++++
 tb/tb_car_alarm_siren_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/car_alarm_pkg.sv
// Shared types and constants for the car-alarm siren controller.
// State codes are plain 2-bit constants; the enum mirrors them for the debug port.
package car_alarm_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] SOUNDING = 2'd2;
    localparam logic [1:0] HOLDOFF  = 2'd3;

    typedef enum logic [1:0] {
        ALARM_IDLE     = 2'd0,
        ALARM_DEBOUNCE = 2'd1,
        ALARM_SOUNDING = 2'd2,
        ALARM_HOLDOFF  = 2'd3
    } alarmState_e;

    localparam int ALARM_COUNT_W = 8;
    localparam logic [ALARM_COUNT_W-1:0] ALARM_COUNT_MAX = 8'd255;

    localparam int DEF_DEBOUNCE_CYCLES  = 4;
    localparam int DEF_BEEP_ON_CYCLES   = 8;
    localparam int DEF_BEEP_OFF_CYCLES  = 8;
    localparam int DEF_MAX_ALARM_CYCLES = 256;
    localparam int DEF_HOLDOFF_CYCLES   = 32;

    function automatic logic [ALARM_COUNT_W-1:0] satInc(input logic [ALARM_COUNT_W-1:0] v);
        return (v == ALARM_COUNT_MAX) ? v : v + ALARM_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/car_alarm_beep_gen.sv
// Beep pattern generator: ON_CYCLES high, OFF_CYCLES low, repeating while enabled.
// The pattern restarts in the ON phase on every rising edge of enable.
module car_alarm_beep_gen #(
    parameter int ON_CYCLES  = 8,
    parameter int OFF_CYCLES = 8
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic enable,
    output logic beep
);

    localparam int PH_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_CYCLES);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_CYCLES);

    logic            enableQ;
    logic [PH_W-1:0] phaseCnt;
    logic            phaseDone;

    // beep itself doubles as the phase flag: 1 = ON phase, 0 = OFF phase
    assign phaseDone = beep ? (phaseCnt == ON_LAST) : (phaseCnt == OFF_LAST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            enableQ  <= 1'b0;
            phaseCnt <= '0;
            beep     <= 1'b0;
        end else begin
            enableQ <= enable;
            if (!enable) begin
                beep     <= 1'b0;
                phaseCnt <= '0;
            end else if (!enableQ) begin
                beep     <= 1'b1;
                phaseCnt <= PH_W'(1);
            end else if (phaseDone) begin
                beep     <= ~beep;
                phaseCnt <= PH_W'(1);
            end else begin
                phaseCnt <= phaseCnt + PH_W'(1);
            end
        end
    end

endmodule

// File: rtl/car_alarm_siren_ctrl.sv
// Car-alarm siren controller: debounce, beep-patterned sounding, timeout and re-trigger holdoff.
// Optional event counter on AlarmCount is enabled by defining ALARM_EVENT_COUNT_EN.
module car_alarm_siren_ctrl
    import car_alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int BEEP_ON_CYCLES   = DEF_BEEP_ON_CYCLES,
    parameter int BEEP_OFF_CYCLES  = DEF_BEEP_OFF_CYCLES,
    parameter int MAX_ALARM_CYCLES = DEF_MAX_ALARM_CYCLES,
    parameter int HOLDOFF_CYCLES   = DEF_HOLDOFF_CYCLES
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     CarAlarmSignal,
    input  logic                     SilenceReq,
    output logic                     SirenOut,
    output logic                     HazardLights,
    output logic                     AlarmActive,
    output logic [ALARM_COUNT_W-1:0] AlarmCount,
    output alarmState_e              StateDbg
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DUR_W = $clog2(MAX_ALARM_CYCLES + 1);
    localparam int HLD_W = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(MAX_ALARM_CYCLES);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLDOFF_CYCLES);

    logic [1:0]       state, stateNext;
    logic [DEB_W-1:0] debCnt, debCntNext;
    logic [DUR_W-1:0] durCnt, durCntNext;
    logic [HLD_W-1:0] holdCnt, holdCntNext;
    logic             soundNext;

    // Both inputs are level-sampled on every rising edge; there is no handshake.
    always_comb begin
        stateNext   = state;
        debCntNext  = debCnt;
        durCntNext  = durCnt;
        holdCntNext = holdCnt;
        case (state)
            IDLE: begin
                if (CarAlarmSignal) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        stateNext  = SOUNDING;
                        debCntNext = '0;
                        durCntNext = DUR_W'(1);
                    end else begin
                        stateNext  = DEBOUNCE;
                        debCntNext = DEB_W'(1);
                    end
                end
            end
            DEBOUNCE: begin
                if (SilenceReq || !CarAlarmSignal) begin
                    stateNext  = IDLE;
                    debCntNext = '0;
                end else if (debCnt + DEB_W'(1) == DEB_LAST) begin
                    stateNext  = SOUNDING;
                    debCntNext = '0;
                    durCntNext = DUR_W'(1);
                end else begin
                    debCntNext = debCnt + DEB_W'(1);
                end
            end
            SOUNDING: begin
                // durCnt counts the current cycle, so DUR_LAST means the budget is used up
                if (SilenceReq || durCnt == DUR_LAST) begin
                    stateNext   = HOLDOFF;
                    durCntNext  = '0;
                    holdCntNext = HLD_W'(1);
                end else begin
                    durCntNext = durCnt + DUR_W'(1);
                end
            end
            HOLDOFF: begin
                if (holdCnt == HLD_LAST) begin
                    stateNext   = IDLE;
                    holdCntNext = '0;
                    debCntNext  = '0;
                end else begin
                    holdCntNext = holdCnt + HLD_W'(1);
                end
            end
            default: begin
                stateNext   = IDLE;
                debCntNext  = '0;
                durCntNext  = '0;
                holdCntNext = '0;
            end
        endcase
    end

    assign soundNext = (stateNext == SOUNDING);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= IDLE;
            debCnt       <= '0;
            durCnt       <= '0;
            holdCnt      <= '0;
            HazardLights <= 1'b0;
            AlarmActive  <= 1'b0;
        end else begin
            state        <= stateNext;
            debCnt       <= debCntNext;
            durCnt       <= durCntNext;
            holdCnt      <= holdCntNext;
            HazardLights <= soundNext;
            AlarmActive  <= soundNext;
        end
    end

    car_alarm_beep_gen #(
        .ON_CYCLES (BEEP_ON_CYCLES),
        .OFF_CYCLES(BEEP_OFF_CYCLES)
    ) u_beep (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .enable(soundNext),
        .beep  (SirenOut)
    );

`ifdef ALARM_EVENT_COUNT_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            AlarmCount <= '0;
        end else if (state != SOUNDING && soundNext) begin
            AlarmCount <= satInc(AlarmCount);
        end
    end
`else
    assign AlarmCount = '0;
`endif

    assign StateDbg = alarmState_e'(state);

endmodule

// File: tb/tb_car_alarm_siren_ctrl.sv
// Bench for car_alarm_siren_ctrl: directed scenarios plus random input traffic,
// each cycle's outputs checked against a timestamp-based reference model.
module tb_car_alarm_siren_ctrl;
    import car_alarm_pkg::*;

    localparam int DEB  = 4;
    localparam int ON   = 8;
    localparam int OFF  = 8;
    localparam int MAXC = 256;
    localparam int HOLD = 32;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        CarAlarmSignal = 1'b0;
    logic        SilenceReq = 1'b0;
    logic        SirenOut;
    logic        HazardLights;
    logic        AlarmActive;
    logic [7:0]  AlarmCount;
    alarmState_e StateDbg;

    int checks = 0;
    int errors = 0;

    // {siren, hazard, active, count}
    logic [10:0] exp_q[$];

    // Reference model: mode 0 idle, 1 debouncing, 2 sounding, 3 holdoff; times are edge indices
    int mMode = 0;
    int mRun = 0;
    int mCycle = 0;
    int mSoundStart = 0;
    int mHoldStart = 0;
    int mCount = 0;

    car_alarm_siren_ctrl dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .CarAlarmSignal(CarAlarmSignal),
        .SilenceReq    (SilenceReq),
        .SirenOut      (SirenOut),
        .HazardLights  (HazardLights),
        .AlarmActive   (AlarmActive),
        .AlarmCount    (AlarmCount),
        .StateDbg      (StateDbg)
    );

    // clock
    always #5 Clk = ~Clk;

    task automatic modelReset();
        mMode  = 0;
        mRun   = 0;
        mCount = 0;
    endtask

    task automatic enterSound();
        mMode       = 2;
        mSoundStart = mCycle;
        mRun        = 0;
        if (mCount < 255) mCount++;
    endtask

    task automatic modelStep(input bit a, input bit s);
        mCycle++;
        case (mMode)
            0: if (a) begin
                mRun = 1;
                if (mRun >= DEB) enterSound();
                else mMode = 1;
            end
            1: begin
                if (s || !a) begin
                    mMode = 0;
                    mRun  = 0;
                end else begin
                    mRun++;
                    if (mRun >= DEB) enterSound();
                end
            end
            2: if (s || (mCycle - mSoundStart) >= MAXC) begin
                mMode      = 3;
                mHoldStart = mCycle;
            end
            default: if (mCycle - mHoldStart >= HOLD) begin
                mMode = 0;
                mRun  = 0;
            end
        endcase
    endtask

    function automatic logic [10:0] modelOut();
        logic       act;
        logic       sir;
        logic [7:0] cnt;
        act = (mMode == 2);
        sir = act && (((mCycle - mSoundStart) % (ON + OFF)) < ON);
`ifdef ALARM_EVENT_COUNT_EN
        cnt = 8'(mCount);
`else
        cnt = 8'd0;
`endif
        return {sir, act, act, cnt};
    endfunction

    // driver: apply inputs, let the DUT sample them, queue the model's response
    task automatic stepCycle(input bit a, input bit s);
        CarAlarmSignal = a;
        SilenceReq     = s;
        @(posedge Clk);
        modelStep(a, s);
        exp_q.push_back(modelOut());
        #1;
    endtask

    task automatic checkNow(input string name, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // scoreboard monitor
    initial begin
        logic [10:0] e;
        logic [10:0] got;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {SirenOut, HazardLights, AlarmActive, AlarmCount};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs at %0t: got siren=%b haz=%b act=%b cnt=%0d expected siren=%b haz=%b act=%b cnt=%0d",
                             $time, got[10], got[9], got[8], got[7:0], e[10], e[9], e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        logic [7:0] satExp;
        modelReset();
        #12;
        checkNow("reset_outputs", {SirenOut, HazardLights, AlarmActive, AlarmCount}, 11'd0);
        checkNow("reset_state", 11'(StateDbg), 11'(ALARM_IDLE));
        @(negedge Clk);
        #2 Rst_n = 1'b1;

        // short pulses never trigger
        repeat (3) stepCycle(1, 0);
        stepCycle(0, 0);
        repeat (3) stepCycle(1, 0);
        repeat (5) stepCycle(0, 0);

        // held high: full timeout, holdoff, re-trigger
        repeat (DEB + MAXC + HOLD + 4 + 20) stepCycle(1, 0);
        repeat (MAXC + HOLD + 10) stepCycle(0, 0);

        // silence 40 cycles into sounding with input held high
        repeat (DEB + 40) stepCycle(1, 0);
        stepCycle(1, 1);
        repeat (HOLD + 12) stepCycle(1, 0);
        stepCycle(1, 1);
        repeat (HOLD + 4) stepCycle(0, 0);

        // asynchronous reset mid-sounding
        repeat (DEB + 20) stepCycle(1, 0);
        @(negedge Clk);
        #2 Rst_n = 1'b0;
        CarAlarmSignal = 1'b0;
        SilenceReq     = 1'b0;
        #1;
        checkNow("async_reset_outputs", {SirenOut, HazardLights, AlarmActive, AlarmCount}, 11'd0);
        checkNow("async_reset_state", 11'(StateDbg), 11'(ALARM_IDLE));
        modelReset();
        @(negedge Clk);
        #2 Rst_n = 1'b1;
        repeat (10) stepCycle(0, 0);

        // 300 short triggers drive the event count into saturation
        for (int t = 0; t < 300; t++) begin
            repeat (DEB) stepCycle(1, 0);
            stepCycle(1, 1);
            repeat (HOLD + 2) stepCycle(0, 0);
        end
        @(negedge Clk);
        #1;
`ifdef ALARM_EVENT_COUNT_EN
        satExp = 8'd255;
`else
        satExp = 8'd0;
`endif
        checkNow("count_saturation", 11'(AlarmCount), 11'(satExp));

        // random traffic: input mostly high, rare silence requests
        for (int i = 0; i < 3000; i++) begin
            stepCycle($urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0);
        end

        @(negedge Clk);
        @(negedge Clk);
        #1;
        checkNow("queue_drained", 11'(exp_q.size()), 11'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
